raster_scanner: RTL and testbench
=================================

Name: raster_scanner

Overview:
Pixel-address generator that sits directly upstream of the start-screen pixel/colour generator and the VGA adapter.
- Sweeps exactly H_RES x V_RES in raster order, with no wasted counts beyond the visible area.
- Issues generator-side coordinates (gx_o/gy_o) to the colour generator.
- Issues delayed adapter-side coordinates and plot (x_o/y_o/plot_o), aligned to the generator's registered colour output.
- Supports one-shot or continuous frames, stall, and frame boundary pulses.

Parameters:
H_RES, 320, pixels per line
V_RES, 240, lines per frame
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
PIPE_DLY, 1, cycles from gx/gy to x_o/y_o/plot_o; legal 0..3

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
start_i  in  1  single-cycle frame start request
cont_i  in  1  level; 1 = restart automatically after each frame
stall_i  in  1  level; freezes scanning and the delay line
gx_o  out  X_W  x to colour generator
gy_o  out  Y_W  y to colour generator
x_o  out  X_W  x to adapter, delayed PIPE_DLY
y_o  out  Y_W  y to adapter, delayed PIPE_DLY
plot_o  out  1  adapter write enable, delayed PIPE_DLY
sof_o  out  1  pulse, aligned with plot_o at (0,0)
eof_o  out  1  pulse, aligned with plot_o at (H_RES-1,V_RES-1)
busy_o  out  1  high from the cycle after accepted start until the last delayed pixel leaves
frame_cnt_o  out  16  completed-frame count (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time including mid-frame): FSM goes to IDLE. All outputs are 0, including gx/gy, x/y, plot, sof, eof, busy and frame_cnt. The delay line is cleared.
- FSM states:
  - IDLE: start_i=1 moves to SCAN on the next edge, with gx/gy=(0,0) in the first SCAN cycle.
  - SCAN: each cycle with stall_i=0, gx increments. At gx=H_RES-1, gx wraps to 0 and gy increments. At (H_RES-1,V_RES-1), next state is:
    - SCAN at (0,0) if cont_i=1 on that cycle;
    - otherwise DRAIN.
  - DRAIN: hold gx/gy, valid=0. Stay PIPE_DLY cycles while the delay line empties, then go to IDLE. With PIPE_DLY=0, DRAIN lasts 0 cycles (direct to IDLE).
- A valid bit travels with each coordinate through a PIPE_DLY-deep shift register. plot_o = delayed valid AND NOT stall_i.
- Stall: gx/gy, the delay line and the FSM all hold. plot_o=0, sof_o=0, eof_o=0 while stalled. Scanning resumes on the exact next pixel, with no skip or duplicate.
- sof/eof are computed from the delayed coordinates. Each asserts for exactly one unstalled cycle per frame.
- start_i is ignored in SCAN and DRAIN. start_i in the same cycle as reset release is ignored (reset dominates).
- cont_i dropping mid-frame: the current frame completes, then the block stops.
- Arithmetic:
  - Comparisons are against H_RES-1 and V_RES-1 at full width.
  - Counters never exceed the visible range. x=320..511 and y=240..255 never appear.
- Throughput: 1 pixel/cycle unstalled, so one frame = 76800 cycles (+PIPE_DLY drain in one-shot mode).
- busy_o stays high across back-to-back continuous frames.

Optional Feature:
Macro SCAN_FRAME_CNT_EN.
- Defined: frame_cnt_o increments by 1 (wrapping at 65535→0) in the cycle eof_o is asserted.
- Undefined: frame_cnt_o is tied to 0 and the counter logic is absent.

Decomposition:
- Shared package holds:
  - resolution constants (H_RES=320, V_RES=240, X_W, Y_W);
  - the FSM state encoding typedef (IDLE, SCAN, DRAIN).
  The colour generator and the adapter wrapper reuse these constants.
- One sub-module: scan_delay_line, a parameterised PIPE_DLY-deep register chain carrying {valid, x, y}, with hold-on-stall and async clear.

Test Plan:
- Reset released, start_i pulse, cont_i=0, PIPE_DLY=1:
  - first plot_o at (0,0) with sof_o=1, 2 cycles after the start edge;
  - exactly 76800 plot cycles;
  - eof_o at (319,239);
  - busy_o falls 1 cycle after eof_o.
- Line wrap: observe gx=319,gy=5 → next cycle gx=0,gy=6. No coordinate with x≥320 or y≥240 ever appears in the run.
- stall_i=1 for 10 cycles at gx=100,gy=50:
  - gx/gy hold for the 10 cycles, plot_o=0;
  - after release, x_o sequence continues 100,101,… with no gap or repeat.
- cont_i=1 for 2 frames:
  - (319,239) followed immediately by (0,0) with sof_o;
  - busy_o never drops;
  - with SCAN_FRAME_CNT_EN, frame_cnt_o=2 after the second eof.
- Reset asserted at gx=200,gy=120 mid-frame: all outputs 0 immediately (asynchronous); the FSM restarts only on a new start_i.
- start_i pulsed during SCAN at (50,10): ignored. Frame count and coordinates are unaffected, and one-shot completion still occurs at (319,239).

Source files
------------

// File: rtl/raster_scanner_pkg.sv
// Shared raster constants and scanner state encoding, also used by the colour generator
// and the adapter wrapper.
package raster_scanner_pkg;

    localparam int unsigned H_RES       = 320;
    localparam int unsigned V_RES       = 240;
    localparam int unsigned X_W         = 9;
    localparam int unsigned Y_W         = 8;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StDrain = 2'd2
    } scan_state_e;

    function automatic logic at_coord(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                      input int unsigned cx, input int unsigned cy);
        return (x == X_W'(cx)) && (y == Y_W'(cy));
    endfunction

endpackage

// File: rtl/raster_scanner_if.sv
// Control and pixel-address bundle of the raster scanner. The master drives start/cont/stall;
// the slave (the scanner) returns coordinates, plot strobes and status.
interface raster_scanner_if;
    import raster_scanner_pkg::*;

    logic                   start_i;
    logic                   cont_i;
    logic                   stall_i;
    logic [X_W-1:0]         gx_o;
    logic [Y_W-1:0]         gy_o;
    logic [X_W-1:0]         x_o;
    logic [Y_W-1:0]         y_o;
    logic                   plot_o;
    logic                   sof_o;
    logic                   eof_o;
    logic                   busy_o;
    logic [FRAME_CNT_W-1:0] frame_cnt_o;

    modport master (
        output start_i, cont_i, stall_i,
        input  gx_o, gy_o, x_o, y_o, plot_o, sof_o, eof_o, busy_o, frame_cnt_o
    );

    modport slave (
        input  start_i, cont_i, stall_i,
        output gx_o, gy_o, x_o, y_o, plot_o, sof_o, eof_o, busy_o, frame_cnt_o
    );

endinterface

// File: rtl/scan_delay_line.sv
// PIPE_DLY-deep register chain that keeps adapter-side coordinates aligned with the colour
// generator's registered output. Holds while stalled; PIPE_DLY = 0 is a plain wire.
module scan_delay_line #(
    parameter int unsigned PIPE_DLY = 1,
    parameter int unsigned Width    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    if (PIPE_DLY == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_pipe
        logic [PIPE_DLY-1:0][Width-1:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d = pipe_q;
            if (!hold_i) begin
                pipe_d[0] = d_i;
                for (int i = 1; i < int'(PIPE_DLY); i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign q_o = pipe_q[PIPE_DLY-1];
    end

endmodule

// File: rtl/raster_scanner.sv
// Raster-order pixel-address generator with a delayed, stall-aware plot stream.
// Optional completed-frame counter enabled by defining SCAN_FRAME_CNT_EN.
module raster_scanner
    import raster_scanner_pkg::*;
#(
    parameter int unsigned HRes     = H_RES,
    parameter int unsigned VRes     = V_RES,
    parameter int unsigned PIPE_DLY = 1
) (
    input logic             clk,
    input logic             reset,
    raster_scanner_if.slave bus
);

    localparam int unsigned    DlyW      = 1 + X_W + Y_W;
    localparam logic [X_W-1:0] XLast     = X_W'(HRes - 1);
    localparam logic [1:0]     DrainLast = (PIPE_DLY == 0) ? 2'd0 : 2'(PIPE_DLY - 1);

    scan_state_e    state_q, state_d;
    logic [X_W-1:0] gx_q, gx_d;
    logic [Y_W-1:0] gy_q, gy_d;
    logic [1:0]     drain_q, drain_d;
    logic           scan_valid;
    logic           frame_last;

    logic [DlyW-1:0] dly_q;
    logic            dly_valid;
    logic [X_W-1:0]  dly_x;
    logic [Y_W-1:0]  dly_y;
    logic            plot, sof, eof;

    assign frame_last = at_coord(gx_q, gy_q, HRes - 1, VRes - 1);

    always_comb begin
        state_d    = state_q;
        gx_d       = gx_q;
        gy_d       = gy_q;
        drain_d    = drain_q;
        scan_valid = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.stall_i) begin
                    state_d = StScan;
                    gx_d    = '0;
                    gy_d    = '0;
                end
            end
            StScan: begin
                scan_valid = 1'b1;
                if (!bus.stall_i) begin
                    if (frame_last) begin
                        if (bus.cont_i) begin
                            gx_d = '0;
                            gy_d = '0;
                        end else begin
                            // Coordinates stay parked on the last pixel while draining.
                            state_d = (PIPE_DLY == 0) ? StIdle : StDrain;
                            drain_d = '0;
                        end
                    end else if (gx_q == XLast) begin
                        gx_d = '0;
                        gy_d = gy_q + Y_W'(1);
                    end else begin
                        gx_d = gx_q + X_W'(1);
                    end
                end
            end
            StDrain: begin
                if (!bus.stall_i) begin
                    if (drain_q == DrainLast) begin
                        state_d = StIdle;
                    end else begin
                        drain_d = drain_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            gx_q    <= '0;
            gy_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            drain_q <= drain_d;
        end
    end

    scan_delay_line #(
        .PIPE_DLY(PIPE_DLY),
        .Width   (DlyW)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .hold_i(bus.stall_i),
        .d_i   ({scan_valid, gx_q, gy_q}),
        .q_o   (dly_q)
    );

    assign {dly_valid, dly_x, dly_y} = dly_q;

    assign plot = dly_valid & ~bus.stall_i;
    assign sof  = plot & at_coord(dly_x, dly_y, 0, 0);
    assign eof  = plot & at_coord(dly_x, dly_y, HRes - 1, VRes - 1);

`ifdef SCAN_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (eof) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.frame_cnt_o = frame_cnt_q;
`else
    assign bus.frame_cnt_o = '0;
`endif

    assign bus.gx_o   = gx_q;
    assign bus.gy_o   = gy_q;
    assign bus.x_o    = dly_x;
    assign bus.y_o    = dly_y;
    assign bus.plot_o = plot;
    assign bus.sof_o  = sof;
    assign bus.eof_o  = eof;
    assign bus.busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_raster_scanner.sv
// Self-checking bench for raster_scanner on a reduced raster; the expected plot stream is
// derived from a running pixel index (x = n mod H, y = n div H).
module tb_raster_scanner;

    localparam int H = 40;
    localparam int V = 30;
    localparam int N = H * V;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    raster_scanner_if bus ();

    raster_scanner #(
        .HRes    (H),
        .VRes    (V),
        .PIPE_DLY(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int   cyc, exp_n, plot_cnt, sof_cnt, eof_cnt, seq_err, range_err, stall_err, busy_hi;
    int   first_plot_cyc, last_eof_cyc, busy_fall_cyc, wrap_seen, wrap_bad, exp_frames;
    int   eof_x, eof_y, bad_n, bad_x, bad_y, prev_gx, prev_gy;
    logic busy_prev;

    function automatic int px_x(input int n);
        return n % H;
    endfunction

    function automatic int px_y(input int n);
        return (n / H) % V;
    endfunction

    task automatic clear_stats();
        cyc = 0; exp_n = 0; plot_cnt = 0; sof_cnt = 0; eof_cnt = 0; seq_err = 0;
        range_err = 0; stall_err = 0; busy_hi = 0; wrap_seen = 0; wrap_bad = 0;
        first_plot_cyc = -1; last_eof_cyc = -1; busy_fall_cyc = -1;
        eof_x = -1; eof_y = -1; bad_n = -1; bad_x = -1; bad_y = -1;
        prev_gx = -1; prev_gy = -1; busy_prev = bus.busy_o;
    endtask

    // One clock: drive inputs just after the edge, observe mid-cycle and update the model.
    task automatic step(input logic st, input logic cn, input logic sl);
        int gx, gy, x, y;
        @(posedge clk);
        #1;
        bus.start_i = st;
        bus.cont_i  = cn;
        bus.stall_i = sl;
        @(negedge clk);
        cyc++;
        gx = int'(bus.gx_o);
        gy = int'(bus.gy_o);
        x  = int'(bus.x_o);
        y  = int'(bus.y_o);
        if (gx >= H || gy >= V || x >= H || y >= V) range_err++;
        if (prev_gx == H - 1 && prev_gy == 5 && (gx != prev_gx || gy != prev_gy)) begin
            wrap_seen++;
            if (gx != 0 || gy != 6) wrap_bad++;
        end
        if (sl && (bus.plot_o || bus.sof_o || bus.eof_o)) stall_err++;
        if (bus.plot_o === 1'b1) begin
            if (first_plot_cyc < 0) first_plot_cyc = cyc;
            if (x != px_x(exp_n) || y != px_y(exp_n) || bus.sof_o !== (exp_n % N == 0) ||
                bus.eof_o !== (exp_n % N == N - 1)) begin
                if (seq_err == 0) begin
                    bad_n = exp_n; bad_x = x; bad_y = y;
                end
                seq_err++;
            end
            if (bus.sof_o) sof_cnt++;
            if (bus.eof_o) begin
                eof_cnt++; last_eof_cyc = cyc; eof_x = x; eof_y = y; exp_frames++;
            end
            exp_n++;
            plot_cnt++;
        end else if (bus.sof_o || bus.eof_o) begin
            seq_err++;
        end
        if (bus.busy_o) busy_hi++;
        if (busy_prev && !bus.busy_o && busy_fall_cyc < 0) busy_fall_cyc = cyc;
        busy_prev = bus.busy_o;
        prev_gx   = gx;
        prev_gy   = gy;
    endtask

    task automatic test_reset();
        bus.start_i = 1'b1; bus.cont_i = 1'b1; bus.stall_i = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.gx_o, bus.gy_o} !== '0) begin
            bad++; $display("FAIL reset.gen_xy: got %0h want 0", {bus.gx_o, bus.gy_o});
        end
        total++;
        if ({bus.x_o, bus.y_o} !== '0) begin
            bad++; $display("FAIL reset.out_xy: got %0h want 0", {bus.x_o, bus.y_o});
        end
        total++;
        if ({bus.plot_o, bus.sof_o, bus.eof_o} !== 3'b000) begin
            bad++; $display("FAIL reset.strobes: got %b want 000",
                            {bus.plot_o, bus.sof_o, bus.eof_o});
        end
        total++;
        if (bus.busy_o !== 1'b0) begin
            bad++; $display("FAIL reset.busy: got %b want 0", bus.busy_o);
        end
        total++;
        if (bus.frame_cnt_o !== 16'd0) begin
            bad++; $display("FAIL reset.frame_cnt: got %0d want 0", bus.frame_cnt_o);
        end
        @(posedge clk);
        #1;
        bus.start_i = 1'b0; bus.cont_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_frames = 0;
        clear_stats();
        repeat (8) step(1'b0, 1'b0, 1'b0);
        total++;
        if (busy_hi + plot_cnt !== 0) begin
            bad++; $display("FAIL reset.idle_after_release: got %0d busy/plot cycles want 0",
                            busy_hi + plot_cnt);
        end
    endtask

    task automatic test_one_shot();
        int start_cyc;
        bit done = 0;
        clear_stats();
        step(1'b1, 1'b0, 1'b0);
        start_cyc = cyc;
        for (int i = 0; i < N + 20 && !done; i++) begin
            step(prev_gx == 5 && prev_gy == 3, 1'b0, 1'b0);  // ignored mid-scan start
            if (busy_fall_cyc >= 0) done = 1;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL one_shot.timeout: got busy still high want busy low");
        end
        total++;
        if (first_plot_cyc - start_cyc !== 2) begin
            bad++; $display("FAIL one_shot.latency: got %0d want 2", first_plot_cyc - start_cyc);
        end
        total++;
        if (plot_cnt !== N) begin
            bad++; $display("FAIL one_shot.plot_count: got %0d want %0d", plot_cnt, N);
        end
        total++;
        if (seq_err !== 0) begin
            bad++; $display("FAIL one_shot.sequence: got %0d errors (pixel %0d at %0d,%0d) want 0",
                            seq_err, bad_n, bad_x, bad_y);
        end
        total++;
        if (sof_cnt !== 1 || eof_cnt !== 1) begin
            bad++; $display("FAIL one_shot.sof_eof_count: got %0d/%0d want 1/1", sof_cnt, eof_cnt);
        end
        total++;
        if (eof_x !== H - 1 || eof_y !== V - 1) begin
            bad++; $display("FAIL one_shot.eof_xy: got (%0d,%0d) want (%0d,%0d)",
                            eof_x, eof_y, H - 1, V - 1);
        end
        total++;
        if (busy_fall_cyc !== last_eof_cyc + 1) begin
            bad++; $display("FAIL one_shot.busy_fall: got cycle %0d want %0d",
                            busy_fall_cyc, last_eof_cyc + 1);
        end
        total++;
        if (range_err !== 0) begin
            bad++; $display("FAIL one_shot.range: got %0d out-of-range cycles want 0", range_err);
        end
        total++;
        if (wrap_seen !== 1 || wrap_bad !== 0) begin
            bad++; $display("FAIL one_shot.line_wrap: got seen=%0d bad=%0d want seen=1 bad=0",
                            wrap_seen, wrap_bad);
        end
        repeat (5) step(1'b0, 1'b0, 1'b0);
        total++;
        if (plot_cnt !== N || bus.busy_o !== 1'b0) begin
            bad++; $display("FAIL one_shot.stays_idle: got plots=%0d busy=%b want %0d/0",
                            plot_cnt, bus.busy_o, N);
        end
    endtask

    task automatic test_stall();
        int  stall_left = 0, stall_cycles = 0, hold_err = 0, post_x = -1, post_y = -1;
        int  release_cyc = -1;
        bit  armed = 1, done = 0;
        logic sl;
        clear_stats();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N + 40 && !done; i++) begin
            sl = 1'b0;
            if (stall_left > 0) begin
                sl = 1'b1; stall_left--;
                if (stall_left == 0) release_cyc = cyc + 2;
            end else if (armed && prev_gx == 9 && prev_gy == 5) begin
                sl = 1'b1; stall_left = 9; armed = 0;
            end
            step(1'b0, 1'b0, sl);
            if (sl) begin
                stall_cycles++;
                if (bus.gx_o != 9'd10 || bus.gy_o != 8'd5) hold_err++;
            end
            if (cyc == release_cyc) begin
                post_x = bus.plot_o ? int'(bus.x_o) : -1;
                post_y = int'(bus.y_o);
            end
            if (busy_fall_cyc >= 0) done = 1;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL stall.timeout: got busy still high want busy low");
        end
        total++;
        if (stall_cycles !== 10 || hold_err !== 0) begin
            bad++; $display("FAIL stall.hold: got %0d stalls, %0d moves want 10, 0",
                            stall_cycles, hold_err);
        end
        total++;
        if (stall_err !== 0) begin
            bad++; $display("FAIL stall.strobes: got %0d strobes while stalled want 0", stall_err);
        end
        total++;
        if (post_x !== 9 || post_y !== 5) begin
            bad++; $display("FAIL stall.resume: got (%0d,%0d) want (9,5)", post_x, post_y);
        end
        total++;
        if (seq_err !== 0 || plot_cnt !== N) begin
            bad++; $display("FAIL stall.sequence: got %0d errors, %0d plots want 0, %0d",
                            seq_err, plot_cnt, N);
        end
    endtask

    task automatic test_random_stall();
        bit   done = 0;
        logic sl, st;
        clear_stats();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3 * N && !done; i++) begin
            sl = ($urandom_range(0, 3) == 0);
            st = bus.busy_o && prev_gy >= 0 && prev_gy < V - 2 && ($urandom_range(0, 63) == 0);
            step(st, 1'b0, sl);
            if (busy_fall_cyc >= 0) done = 1;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL random_stall.timeout: got busy still high want busy low");
        end
        total++;
        if (plot_cnt !== N || seq_err !== 0) begin
            bad++; $display("FAIL random_stall.sequence: got %0d plots, %0d errors want %0d, 0",
                            plot_cnt, seq_err, N);
        end
        total++;
        if (stall_err !== 0 || range_err !== 0) begin
            bad++; $display("FAIL random_stall.gating: got stall=%0d range=%0d want 0/0",
                            stall_err, range_err);
        end
        total++;
        if (sof_cnt !== 1 || eof_cnt !== 1) begin
            bad++; $display("FAIL random_stall.sof_eof: got %0d/%0d want 1/1", sof_cnt, eof_cnt);
        end
    endtask

    task automatic test_continuous();
        bit done = 0, seam_ok = 0;
        int exp_fc;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_frames = 0;
        clear_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2 * N + 20 && !done; i++) begin
            step(1'b0, exp_n < N + N / 2, 1'b0);
            if (eof_cnt == 1 && cyc == last_eof_cyc + 1) begin
                seam_ok = bus.plot_o && bus.sof_o && bus.x_o == '0 && bus.y_o == '0;
            end
            if (busy_fall_cyc >= 0) done = 1;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL continuous.timeout: got busy still high want busy low");
        end
        total++;
        if (plot_cnt !== 2 * N || seq_err !== 0) begin
            bad++; $display("FAIL continuous.sequence: got %0d plots, %0d errors want %0d, 0",
                            plot_cnt, seq_err, 2 * N);
        end
        total++;
        if (sof_cnt !== 2 || eof_cnt !== 2) begin
            bad++; $display("FAIL continuous.sof_eof: got %0d/%0d want 2/2", sof_cnt, eof_cnt);
        end
        total++;
        if (!seam_ok) begin
            bad++; $display("FAIL continuous.seam: got no (0,0)+sof after eof want it next cycle");
        end
        total++;
        if (busy_fall_cyc !== last_eof_cyc + 1) begin
            bad++; $display("FAIL continuous.busy: got fall at %0d want %0d",
                            busy_fall_cyc, last_eof_cyc + 1);
        end
`ifdef SCAN_FRAME_CNT_EN
        exp_fc = exp_frames % 65536;
`else
        exp_fc = 0;
`endif
        total++;
        if (int'(bus.frame_cnt_o) !== exp_fc) begin
            bad++; $display("FAIL continuous.frame_cnt: got %0d want %0d", bus.frame_cnt_o, exp_fc);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit reached = 0;
        int start_cyc;
        clear_stats();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N && !reached; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus.gx_o == 9'd25 && bus.gy_o == 8'd15) reached = 1;
        end
        total++;
        if (!reached) begin
            bad++; $display("FAIL mid_reset.reach: got no (25,15) want it within a frame");
        end
        reset = 1'b0;
        #1;
        exp_frames = 0;
        total++;
        if ({bus.gx_o, bus.gy_o, bus.x_o, bus.y_o, bus.plot_o, bus.sof_o, bus.eof_o, bus.busy_o,
             bus.frame_cnt_o} !== '0) begin
            bad++; $display("FAIL mid_reset.async_clear: got %0h want 0",
                            {bus.gx_o, bus.gy_o, bus.x_o, bus.y_o, bus.plot_o, bus.busy_o});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_stats();
        repeat (20) step(1'b0, 1'b0, 1'b0);
        total++;
        if (busy_hi + plot_cnt !== 0) begin
            bad++; $display("FAIL mid_reset.no_restart: got %0d busy/plot cycles want 0",
                            busy_hi + plot_cnt);
        end
        step(1'b1, 1'b0, 1'b0);
        start_cyc = cyc;
        repeat (6) step(1'b0, 1'b0, 1'b0);
        total++;
        if (first_plot_cyc - start_cyc !== 2 || plot_cnt !== 5 || seq_err !== 0) begin
            bad++; $display("FAIL mid_reset.restart: got lat=%0d plots=%0d err=%0d want 2/5/0",
                            first_plot_cyc - start_cyc, plot_cnt, seq_err);
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.cont_i  = 1'b0;
        bus.stall_i = 1'b0;
        exp_frames  = 0;
        test_reset();
        test_one_shot();
        test_stall();
        test_random_stall();
        test_continuous();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
